// File: rtl/dct_stream_pkg.sv
// dct_stream_pkg: width derivation helpers and FSM state encoding shared by the DCT stream slice.
package dct_stream_pkg;

  localparam logic [1:0] S_ACCEPT = 2'd0;
  localparam logic [1:0] S_MAC    = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;

  // Accumulator holds FRAME_LEN full-width products without overflow.
  function automatic int acc_bw(input int i_bw, input int coef_bw, input int frame_len);
    return i_bw + 1 + coef_bw + $clog2(frame_len);
  endfunction

  function automatic int addr_bw(input int frame_len, input int n_coef);
    return (frame_len * n_coef > 1) ? $clog2(frame_len * n_coef) : 1;
  endfunction

  function automatic int idx_bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dct_stream_if.sv
// dct_stream_if: sample input stream and coefficient output stream of dct_stream.
interface dct_stream_if #(
  parameter int I_BW = 8,
  parameter int O_BW = 16
);
  logic [I_BW-1:0] data_i;
  logic            valid_i;
  logic            last_i;
  logic            ready_o;
  logic [O_BW-1:0] data_o;
  logic            valid_o;
  logic            last_o;
  logic            ready_i;

  modport slave (
    input  data_i, valid_i, last_i, ready_i,
    output ready_o, data_o, valid_o, last_o
  );

  modport master (
    output data_i, valid_i, last_i, ready_i,
    input  ready_o, data_o, valid_o, last_o
  );
endinterface

// File: rtl/dct_stream_coef_rom.sv
// dct_stream_coef_rom: registered-read coefficient ROM; INIT is the row-major [elem][coef] image.
module dct_stream_coef_rom #(
  parameter int COEF_BW = 16,
  parameter int DEPTH   = 416,
  parameter int ADDR_BW = 9,
  parameter logic [DEPTH*COEF_BW-1:0] INIT = '0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [ADDR_BW-1:0] addr,
  output logic [COEF_BW-1:0] q
);

  logic [COEF_BW-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = INIT[i*COEF_BW +: COEF_BW];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) q <= '0;
    else          q <= rom[addr];
  end

endmodule

// File: rtl/dct_stream.sv
// dct_stream: serial-MAC DCT over valid/ready streams; N_COEF MACs per sample, N_COEF outputs per frame.
// Build option DCT_STREAM_SATURATE_EN clamps outputs to O_BW; otherwise outputs wrap to O_BW bits.
//  state    | meaning
//  S_ACCEPT | waiting for the next sample, ready_o high
//  S_MAC    | one MAC per cycle into acc[k] for the held sample
//  S_EMIT   | presenting fmt(acc[k]) downstream, advancing on ready_i
module dct_stream
  import dct_stream_pkg::*;
#(
  parameter int I_BW      = 8,
  parameter int O_BW      = 16,
  parameter int COEF_BW   = 16,
  parameter int FRAME_LEN = 32,
  parameter int N_COEF    = 13,
  parameter int SHIFT     = 15,
  parameter logic [FRAME_LEN*N_COEF*COEF_BW-1:0] COEF_INIT =
    {(FRAME_LEN*N_COEF){COEF_BW'(16'h4000)}}
) (
  input logic          clk_i,
  input logic          rst_n_i,
  input logic          en_i,
  dct_stream_if.slave  bus
);

  localparam int ACC_BW  = acc_bw(I_BW, COEF_BW, FRAME_LEN);
  localparam int PROD_BW = I_BW + 1 + COEF_BW;
  localparam int DEPTH   = FRAME_LEN * N_COEF;
  localparam int ADDR_BW = addr_bw(FRAME_LEN, N_COEF);
  localparam int EL_BW   = idx_bw(FRAME_LEN);
  localparam int K_BW    = idx_bw(N_COEF);
  localparam logic [EL_BW-1:0] EL_LAST = EL_BW'(FRAME_LEN - 1);
  localparam logic [K_BW-1:0]  K_LAST  = K_BW'(N_COEF - 1);

  logic [1:0]                state;
  logic [EL_BW-1:0]          elem;
  logic [K_BW-1:0]           k;
  logic signed [I_BW:0]      x_q;
  logic                      frame_end;
  logic signed [ACC_BW-1:0]  acc [N_COEF];
  logic [ADDR_BW-1:0]        row_base;
  logic [ADDR_BW-1:0]        rom_addr;
  logic signed [COEF_BW-1:0] coef;
  logic signed [PROD_BW-1:0] prod;
  logic signed [ACC_BW-1:0]  acc_sel;
  logic [O_BW-1:0]           fmt;
  logic                      ready;
  logic                      emit_v;

  assign row_base = ADDR_BW'(elem) * ADDR_BW'(N_COEF);

  // Address runs one step ahead of k so the registered ROM output lines up with each MAC cycle.
  assign rom_addr = (state == S_MAC && k != K_LAST) ? row_base + ADDR_BW'(k) + ADDR_BW'(1)
                                                    : row_base;

  dct_stream_coef_rom #(
    .COEF_BW (COEF_BW),
    .DEPTH   (DEPTH),
    .ADDR_BW (ADDR_BW),
    .INIT    (COEF_INIT)
  ) u_rom (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .addr    (rom_addr),
    .q       (coef)
  );

  assign prod = PROD_BW'(x_q) * PROD_BW'(coef);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_ACCEPT;
      elem      <= '0;
      k         <= '0;
      x_q       <= '0;
      frame_end <= 1'b0;
      for (int i = 0; i < N_COEF; i++) acc[i] <= '0;
    end else if (!en_i) begin
      state     <= S_ACCEPT;
      elem      <= '0;
      k         <= '0;
      x_q       <= '0;
      frame_end <= 1'b0;
      for (int i = 0; i < N_COEF; i++) acc[i] <= '0;
    end else begin
      case (state)
        S_ACCEPT: begin
          if (bus.valid_i) begin
            x_q       <= {1'b0, bus.data_i};
            frame_end <= bus.last_i;
            k         <= '0;
            state     <= S_MAC;
          end
        end
        S_MAC: begin
          acc[k] <= acc[k] + ACC_BW'(prod);
          if (k == K_LAST) begin
            k <= '0;
            // Short frames close early; missing samples contribute nothing.
            if (elem == EL_LAST || frame_end) begin
              state <= S_EMIT;
            end else begin
              elem  <= elem + EL_BW'(1);
              state <= S_ACCEPT;
            end
          end else begin
            k <= k + K_BW'(1);
          end
        end
        S_EMIT: begin
          if (bus.ready_i) begin
            if (k == K_LAST) begin
              for (int i = 0; i < N_COEF; i++) acc[i] <= '0;
              elem  <= '0;
              k     <= '0;
              state <= S_ACCEPT;
            end else begin
              k <= k + K_BW'(1);
            end
          end
        end
        default: state <= S_ACCEPT;
      endcase
    end
  end

  assign acc_sel = acc[k];

`ifdef DCT_STREAM_SATURATE_EN
  localparam logic signed [ACC_BW-1:0] SAT_MAX = {{(ACC_BW-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] SAT_MIN = {{(ACC_BW-O_BW+1){1'b1}}, {(O_BW-1){1'b0}}};
  logic signed [ACC_BW-1:0] acc_shr;

  assign acc_shr = acc_sel >>> SHIFT;

  always_comb begin
    fmt = acc_shr[O_BW-1:0];
    if (acc_shr > SAT_MAX)      fmt = SAT_MAX[O_BW-1:0];
    else if (acc_shr < SAT_MIN) fmt = SAT_MIN[O_BW-1:0];
  end
`else
  assign fmt = O_BW'(acc_sel >>> SHIFT);
`endif

  assign ready  = en_i && (state == S_ACCEPT);
  assign emit_v = en_i && (state == S_EMIT);

  assign bus.ready_o = ready;
  assign bus.valid_o = emit_v;
  assign bus.last_o  = emit_v && (k == K_LAST);
  assign bus.data_o  = emit_v ? fmt : '0;

endmodule

// File: tb/tb_dct_stream.sv
// tb_dct_stream: directed vector table over three dct_stream builds plus reset/enable corner sequences.
module tb_dct_stream;

  localparam int NC = 13;
  localparam int FL = 32;

  function automatic logic [FL*NC*16-1:0] make_vrom();
    logic [FL*NC*16-1:0] rv;
    rv = '0;
    for (int e = 0; e < FL; e++)
      for (int c = 0; c < NC; c++)
        rv[(e*NC+c)*16 +: 16] = 16'((c + 1) * 1024 + 16 * e);
    return rv;
  endfunction

  localparam logic [FL*NC*16-1:0] VROM = make_vrom();
  localparam logic [FL*NC*16-1:0] OROM = {(FL*NC){16'h7FFF}};

`ifdef DCT_STREAM_SATURATE_EN
  localparam int OVF_EXP = 32767;
`else
  localparam int OVF_EXP = -8160;
`endif

  typedef struct {
    int sel;
    int n;
    int base;
    int step;
    bit use_last;
    bit bp;
    int exp0;
    int estep;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] d;
  logic       v;
  logic       l;
  logic       r;
  int         sel;

  int n_vec = 0;
  int n_bad = 0;

  dct_stream_if #(.I_BW(8), .O_BW(16)) b0 ();
  dct_stream_if #(.I_BW(8), .O_BW(16)) b1 ();
  dct_stream_if #(.I_BW(8), .O_BW(16)) b2 ();

  assign b0.data_i = d;
  assign b1.data_i = d;
  assign b2.data_i = d;
  assign b0.valid_i = v && (sel == 0);
  assign b1.valid_i = v && (sel == 1);
  assign b2.valid_i = v && (sel == 2);
  assign b0.last_i = l && (sel == 0);
  assign b1.last_i = l && (sel == 1);
  assign b2.last_i = l && (sel == 2);
  assign b0.ready_i = r;
  assign b1.ready_i = r;
  assign b2.ready_i = r;

  logic        o_ready;
  logic        o_valid;
  logic        o_last;
  logic [15:0] o_data;

  assign o_ready = (sel == 0) ? b0.ready_o : (sel == 1) ? b1.ready_o : b2.ready_o;
  assign o_valid = (sel == 0) ? b0.valid_o : (sel == 1) ? b1.valid_o : b2.valid_o;
  assign o_last  = (sel == 0) ? b0.last_o  : (sel == 1) ? b1.last_o  : b2.last_o;
  assign o_data  = (sel == 0) ? b0.data_o  : (sel == 1) ? b1.data_o  : b2.data_o;

  dct_stream u_main (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .en_i    (en),
    .bus     (b0)
  );

  dct_stream #(.SHIFT(0), .COEF_INIT(OROM)) u_ovf (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .en_i    (en),
    .bus     (b1)
  );

  dct_stream #(.SHIFT(4), .COEF_INIT(VROM)) u_var (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .en_i    (en),
    .bus     (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!o_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!o_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic feed(input vec_t t);
    int lat;
    sel = t.sel;
    for (int i = 0; i < t.n; i++) begin
      wait_ready();
      d = 8'(t.base + t.step * i);
      v = 1'b1;
      l = t.use_last && (i == t.n - 1);
      @(negedge clk);
      v = 1'b0;
      l = 1'b0;
    end
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, NC + 1);
  endtask

  task automatic rx(input vec_t t);
    int j;
    int cyc;
    j = 0;
    cyc = 0;
    while (j < NC && cyc < 2000) begin
      if (o_valid) begin
        chk("data", longint'($signed(o_data)), longint'(t.exp0 + t.estep * j));
        chk("last", longint'(o_last), longint'(j == NC - 1));
        chk("ready_in_emit", longint'(o_ready), 0);
      end
      r = t.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_valid && r) j++;
      @(negedge clk);
      cyc++;
    end
    r = 1'b1;
    if (j < NC) chk("rx_timeout", j, NC);
    if (!t.bp) chk("burst_len", cyc, NC);
    chk("idle_valid", longint'(o_valid), 0);
    chk("idle_ready", longint'(o_ready), 1);
  endtask

  task automatic run_vec(input vec_t t);
    feed(t);
    rx(t);
  endtask

  vec_t vecs[12];
  vec_t t6;

  initial begin
    vecs[0]  = '{0, 32,  10, 0, 1, 0,  160,    0};
    vecs[1]  = '{0,  4, 100, 0, 1, 0,  200,    0};
    vecs[2]  = '{0, 32,  10, 0, 1, 1,  160,    0};
    vecs[3]  = '{0, 32,  10, 0, 0, 0,  160,    0};
    vecs[4]  = '{0,  1, 255, 0, 1, 0,  127,    0};
    vecs[5]  = '{0,  2,   7, 0, 1, 1,    7,    0};
    vecs[6]  = '{0, 32, 255, 0, 1, 0, 4080,    0};
    vecs[7]  = '{0, 31,   1, 0, 1, 0,   15,    0};
    vecs[8]  = '{1, 32, 255, 0, 1, 0, OVF_EXP, 0};
    vecs[9]  = '{2,  3,   1, 1, 1, 0,  392,  384};
    vecs[10] = '{2,  2,   5, 0, 1, 1,  645,  640};
    vecs[11] = '{2, 32,   1, 0, 1, 0, 2544, 2048};
    t6       = '{0,  2,  50, 0, 1, 0,   50,    0};

    rst_n = 1'b0;
    en    = 1'b1;
    d     = '0;
    v     = 1'b0;
    l     = 1'b0;
    r     = 1'b1;
    sel   = 0;
    @(negedge clk);
    chk("rst_valid_held", longint'(o_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", longint'(o_valid), 0);
    chk("rst_ready", longint'(o_ready), 1);
    chk("rst_last", longint'(o_last), 0);
    chk("rst_data", longint'(o_data), 0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Async reset in the middle of a MAC sequence drops the partial frame.
    sel = 0;
    wait_ready();
    d = 8'd200;
    v = 1'b1;
    @(negedge clk);
    v = 1'b0;
    @(negedge clk);
    chk("mac_busy", longint'(o_ready), 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", longint'(o_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", longint'(o_ready), 1);
    chk("midrst_valid2", longint'(o_valid), 0);
    run_vec(vecs[1]);

    // Enable dropped part way through the emit phase.
    feed(t6);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("emit_mid_data", longint'($signed(o_data)), 50);
    chk("emit_mid_last", longint'(o_last), 0);
    r  = 1'b0;
    en = 1'b0;
    @(negedge clk);
    chk("en_valid", longint'(o_valid), 0);
    chk("en_last", longint'(o_last), 0);
    chk("en_data", longint'(o_data), 0);
    chk("en_ready", longint'(o_ready), 0);
    en = 1'b1;
    r  = 1'b1;
    @(negedge clk);
    chk("reen_ready", longint'(o_ready), 1);
    chk("reen_valid", longint'(o_valid), 0);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
